// File: rtl/pipe_hazard_ctrl.sv
// Hazard and scheduling controller for the 5-stage pipeline: stalls, flushes, EX forwarding,
// mul/div wait sequencing, fetch wait states and redirect-during-fetch tracking.
module pipe_hazard_ctrl #(
   parameter int REG_AW     = 5,
   parameter int MD_TIMEOUT = 40
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] rs1_D,
   input  logic [REG_AW-1:0] rs2_D,
   input  logic              use_rs1_D,
   input  logic              use_rs2_D,
   input  logic [REG_AW-1:0] rs1_E,
   input  logic [REG_AW-1:0] rs2_E,
   input  logic [REG_AW-1:0] rd_E,
   input  logic              memread_E,
   input  logic [REG_AW-1:0] rd_M,
   input  logic              regwrite_M,
   input  logic [REG_AW-1:0] rd_W,
   input  logic              regwrite_W,
   input  logic              redirect_E,
   input  logic              md_start_E,
   input  logic              md_done,
   input  logic              imem_ready,
   output logic              stall_F,
   output logic              stall_D,
   output logic              flush_D,
   output logic              stall_E,
   output logic              flush_E,
   output logic              flush_M,
   output logic [1:0]        fwd_a_E,
   output logic [1:0]        fwd_b_E,
   output logic              md_timeout,
   output logic [31:0]       perf_stalls
);

   localparam int CW = $clog2(MD_TIMEOUT + 1);

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] md_cnt_q, md_cnt_d;
   logic          redir_pend_q, redir_pend_d;
   logic          md_timeout_q, md_timeout_d;
   logic [31:0]   perf_q, perf_d;

   logic          load_use;
   logic          c_stall_f, c_stall_d, c_flush_d, c_stall_e, c_flush_e, c_flush_m;
   logic [1:0]    c_fwd_a, c_fwd_b;

   // MEM result is younger than WB, so it wins; x0 never matches a writer.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rdm, input logic wm,
                                          input logic [REG_AW-1:0] rdw, input logic ww);
      if (wm && (rdm != '0) && (rdm == rs))      return 2'b10;
      else if (ww && (rdw != '0) && (rdw == rs)) return 2'b01;
      else                                       return 2'b00;
   endfunction

   assign load_use = memread_E && (rd_E != '0) &&
                     ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));

   assign c_fwd_a = fwd_sel(rs1_E, rd_M, regwrite_M, rd_W, regwrite_W);
   assign c_fwd_b = fwd_sel(rs2_E, rd_M, regwrite_M, rd_W, regwrite_W);

   always_comb begin
      state_d      = state_q;
      md_cnt_d     = md_cnt_q;
      redir_pend_d = redir_pend_q;
      md_timeout_d = md_timeout_q;
      c_stall_f    = 1'b0;
      c_stall_d    = 1'b0;
      c_flush_d    = 1'b0;
      c_stall_e    = 1'b0;
      c_flush_e    = 1'b0;
      c_flush_m    = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect_E) begin
               c_flush_d    = 1'b1;
               c_flush_e    = 1'b1;
               redir_pend_d = !imem_ready;
            end else if (md_start_E && !md_done) begin
               {c_stall_f, c_stall_d, c_stall_e, c_flush_m} = 4'b1111;
               state_d  = MD_WAIT;
               md_cnt_d = CW'(1);
            end else if (load_use) begin
               c_stall_f = 1'b1;
               c_stall_d = 1'b1;
               c_flush_e = 1'b1;
            end else if (!imem_ready) begin
               c_stall_f = 1'b1;
               c_flush_d = 1'b1;
            end else if (redir_pend_q) begin
               // Fetch returned after a redirect: that word is wrong-path.
               c_flush_d    = 1'b1;
               redir_pend_d = 1'b0;
            end
         end
         MD_WAIT: begin
            if (md_done) begin
               state_d  = RUN;
               md_cnt_d = '0;
            end else if (md_cnt_q == CW'(MD_TIMEOUT - 1)) begin
               md_timeout_d = 1'b1;
               state_d      = RUN;
               md_cnt_d     = '0;
            end else begin
               {c_stall_f, c_stall_d, c_stall_e, c_flush_m} = 4'b1111;
               md_cnt_d = md_cnt_q + CW'(1);
            end
         end
         default: state_d = RUN;
      endcase
      perf_d = perf_q + {31'b0, c_stall_f};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= RUN;
         md_cnt_q     <= '0;
         redir_pend_q <= 1'b0;
         md_timeout_q <= 1'b0;
         perf_q       <= '0;
      end else begin
         state_q      <= state_d;
         md_cnt_q     <= md_cnt_d;
         redir_pend_q <= redir_pend_d;
         md_timeout_q <= md_timeout_d;
         perf_q       <= perf_d;
      end
   end

   assign stall_F     = reset_n & c_stall_f;
   assign stall_D     = reset_n & c_stall_d;
   assign flush_D     = reset_n & c_flush_d;
   assign stall_E     = reset_n & c_stall_e;
   assign flush_E     = reset_n & c_flush_e;
   assign flush_M     = reset_n & c_flush_m;
   assign fwd_a_E     = reset_n ? c_fwd_a : 2'b00;
   assign fwd_b_E     = reset_n ? c_fwd_b : 2'b00;
   assign md_timeout  = reset_n & md_timeout_q;
   assign perf_stalls = perf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int AW  = 5;
   localparam int MDT = 6;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic          use_rs1_D, use_rs2_D, memread_E, regwrite_M, regwrite_W;
   logic          redirect_E, md_start_E, md_done, imem_ready;
   logic          stall_F, stall_D, flush_D, stall_E, flush_E, flush_M, md_timeout;
   logic [1:0]    fwd_a_E, fwd_b_E;
   logic [31:0]   perf_stalls;

   logic [10:0]   ctrl;
   assign ctrl = {stall_F, stall_D, flush_D, stall_E, flush_E, flush_M,
                  fwd_a_E, fwd_b_E, md_timeout};

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   bit          m_md, m_pend, m_to;
   int          m_age;
   logic [31:0] m_perf = '0;
   bit          nx_md, nx_pend, nx_to;
   int          nx_age;
   logic [31:0] nx_perf;
   logic [10:0] exp_ctrl;
   logic [31:0] exp_perf;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(AW), .MD_TIMEOUT(MDT)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
      .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .memread_E(memread_E),
      .rd_M(rd_M), .regwrite_M(regwrite_M), .rd_W(rd_W), .regwrite_W(regwrite_W),
      .redirect_E(redirect_E), .md_start_E(md_start_E), .md_done(md_done),
      .imem_ready(imem_ready),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .stall_E(stall_E),
      .flush_E(flush_E), .flush_M(flush_M), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
      .md_timeout(md_timeout), .perf_stalls(perf_stalls)
   );

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
      if (rs == 0) return 2'b00;
      if (regwrite_M && rd_M == rs) return 2'b10;
      if (regwrite_W && rd_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_eval();
      bit sf = 0, sd = 0, fd = 0, se = 0, fe = 0, fm = 0, lu;
      nx_md = m_md; nx_age = m_age; nx_pend = m_pend; nx_to = m_to;
      lu = memread_E && rd_E != 0 &&
           ((use_rs1_D && rs1_D == rd_E) || (use_rs2_D && rs2_D == rd_E));
      if (!reset_n) begin
         exp_ctrl = '0;
         nx_md = 0; nx_age = 0; nx_pend = 0; nx_to = 0;
         exp_perf = m_perf;
         nx_perf  = '0;
      end else begin
         if (m_md) begin
            if (md_done) nx_md = 0;
            else if (m_age == MDT - 1) begin nx_md = 0; nx_to = 1; end
            else begin sf = 1; sd = 1; se = 1; fm = 1; nx_age = m_age + 1; end
         end else if (redirect_E) begin
            fd = 1; fe = 1; nx_pend = !imem_ready;
         end else if (md_start_E && !md_done) begin
            sf = 1; sd = 1; se = 1; fm = 1; nx_md = 1; nx_age = 1;
         end else if (lu) begin
            sf = 1; sd = 1; fe = 1;
         end else if (!imem_ready) begin
            sf = 1; fd = 1;
         end else if (m_pend) begin
            fd = 1; nx_pend = 0;
         end
         exp_ctrl = {sf, sd, fd, se, fe, fm, m_fwd(rs1_E), m_fwd(rs2_E), m_to};
         exp_perf = m_perf;
         nx_perf  = m_perf + (sf ? 32'd1 : 32'd0);
      end
   endtask

   task automatic settle();
      model_eval();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      m_md = nx_md; m_age = nx_age; m_pend = nx_pend; m_to = nx_to; m_perf = nx_perf;
      #1;
   endtask

   task automatic idle();
      reset_n = 1; rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0;
      rs1_E = 0; rs2_E = 0; rd_E = 0; memread_E = 0; rd_M = 0; regwrite_M = 0;
      rd_W = 0; regwrite_W = 0; redirect_E = 0; md_start_E = 0; md_done = 0;
      imem_ready = 1;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 0; md_start_E = 1; imem_ready = 0; redirect_E = 1;
      regwrite_M = 1; rd_M = 3; rs1_E = 3;
      settle(); adv();
      settle();
      n_tests++;
      if (ctrl !== 11'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %b want 0", ctrl);
      end
      n_tests++;
      if (perf_stalls !== 32'd0) begin
         n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_stalls);
      end
      adv();
      idle(); settle(); adv();
   endtask

   task automatic test_load_use();
      logic [31:0] p0;
      idle();
      memread_E = 1; rd_E = 5; use_rs1_D = 1; rs1_D = 5;
      settle();
      p0 = perf_stalls;
      n_tests++;
      if (ctrl[10:5] !== 6'b110010) begin
         n_fail++; $display("FAIL load_use_stall: got %b want 110010", ctrl[10:5]);
      end
      adv();
      idle();
      rs1_E = 5; rd_E = 9; regwrite_W = 1; rd_W = 5;
      settle();
      n_tests++;
      if (fwd_a_E !== 2'b01 || ctrl[10:5] !== 6'b0) begin
         n_fail++; $display("FAIL load_use_fwd: got fwd_a=%b ctl=%b want 01/000000", fwd_a_E, ctrl[10:5]);
      end
      n_tests++;
      if (perf_stalls !== p0 + 32'd1) begin
         n_fail++; $display("FAIL load_use_perf: got %0d want %0d", perf_stalls, p0 + 1);
      end
      adv();
   endtask

   task automatic test_redirect_lu();
      idle();
      memread_E = 1; rd_E = 4; use_rs2_D = 1; rs2_D = 4; redirect_E = 1;
      settle();
      n_tests++;
      if (ctrl[10:5] !== 6'b001010) begin
         n_fail++; $display("FAIL redirect_over_lu: got %b want 001010", ctrl[10:5]);
      end
      adv();
   endtask

   task automatic test_md_done();
      logic [31:0] p0;
      int hi = 0;
      bit bad = 0;
      idle(); settle(); p0 = perf_stalls; adv();
      for (int c = 1; c <= 4; c++) begin
         md_start_E = 1; md_done = (c == 4);
         settle();
         if (c < 4 && ctrl[10:5] !== 6'b110101) bad = 1;
         if (c == 4 && ctrl[10:5] !== 6'b0) bad = 1;
         if (stall_F) hi++;
         adv();
      end
      idle(); settle();
      n_tests++;
      if (bad || hi != 3) begin
         n_fail++; $display("FAIL md_done_stalls: got %0d stall cycles (shape_bad=%0d) want 3", hi, bad);
      end
      n_tests++;
      if (perf_stalls !== p0 + 32'd3) begin
         n_fail++; $display("FAIL md_done_perf: got %0d want %0d", perf_stalls, p0 + 3);
      end
      adv();
   endtask

   task automatic test_redir_pend();
      idle();
      redirect_E = 1; imem_ready = 0;
      settle();
      n_tests++;
      if (ctrl[10:5] !== 6'b001010) begin
         n_fail++; $display("FAIL pend_redirect: got %b want 001010", ctrl[10:5]);
      end
      adv();
      redirect_E = 0; imem_ready = 0;
      settle(); adv();
      imem_ready = 1;
      settle();
      n_tests++;
      if (ctrl[10:5] !== 6'b001000) begin
         n_fail++; $display("FAIL pend_flush: got %b want 001000", ctrl[10:5]);
      end
      adv();
      settle();
      n_tests++;
      if (ctrl[10:5] !== 6'b0) begin
         n_fail++; $display("FAIL pend_cleared: got %b want 000000", ctrl[10:5]);
      end
      adv();
   endtask

   task automatic test_fwd();
      idle();
      rd_M = 7; rd_W = 7; regwrite_M = 1; regwrite_W = 1; rs2_E = 7; rs1_E = 2;
      settle();
      n_tests++;
      if (fwd_b_E !== 2'b10 || fwd_a_E !== 2'b00) begin
         n_fail++; $display("FAIL fwd_mem_wins: got a=%b b=%b want 00/10", fwd_a_E, fwd_b_E);
      end
      adv();
      regwrite_M = 0;
      settle();
      n_tests++;
      if (fwd_b_E !== 2'b01) begin
         n_fail++; $display("FAIL fwd_wb: got %b want 01", fwd_b_E);
      end
      adv();
      rd_M = 0; rd_W = 0; regwrite_M = 1; regwrite_W = 1; rs2_E = 0; rs1_E = 0;
      settle();
      n_tests++;
      if (fwd_b_E !== 2'b00 || fwd_a_E !== 2'b00) begin
         n_fail++; $display("FAIL fwd_x0: got a=%b b=%b want 00/00", fwd_a_E, fwd_b_E);
      end
      adv();
   endtask

   task automatic test_md_timeout();
      int hi = 0;
      idle();
      for (int c = 0; c < MDT; c++) begin
         md_start_E = 1;
         settle();
         if (stall_F) hi++;
         adv();
      end
      n_tests++;
      if (hi != MDT - 1) begin
         n_fail++; $display("FAIL md_timeout_len: got %0d stall cycles want %0d", hi, MDT - 1);
      end
      idle();
      settle();
      n_tests++;
      if (md_timeout !== 1'b1 || stall_F !== 1'b0) begin
         n_fail++; $display("FAIL md_timeout_set: got to=%b stall_F=%b want 1/0", md_timeout, stall_F);
      end
      adv();
      for (int c = 0; c < 3; c++) begin settle(); adv(); end
      settle();
      n_tests++;
      if (md_timeout !== 1'b1) begin
         n_fail++; $display("FAIL md_timeout_sticky: got %b want 1", md_timeout);
      end
      adv();
   endtask

   task automatic test_reset_md();
      idle();
      md_start_E = 1;
      settle(); adv();
      settle(); adv();
      reset_n = 0;
      settle();
      n_tests++;
      if (ctrl !== 11'b0) begin
         n_fail++; $display("FAIL reset_in_md_outputs: got %b want 0", ctrl);
      end
      adv();
      idle();
      settle();
      n_tests++;
      if (ctrl[10:5] !== 6'b0 || md_timeout !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_md_run: got ctl=%b to=%b want 000000/0", ctrl[10:5], md_timeout);
      end
      adv();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 3000; c++) begin
         reset_n    = ($urandom_range(99) != 0);
         rs1_D      = AW'($urandom_range(7)); rs2_D = AW'($urandom_range(7));
         use_rs1_D  = 1'($urandom); use_rs2_D = 1'($urandom);
         rs1_E      = AW'($urandom_range(7)); rs2_E = AW'($urandom_range(7));
         rd_E       = AW'($urandom_range(7)); memread_E = ($urandom_range(2) == 0);
         rd_M       = AW'($urandom_range(7)); regwrite_M = 1'($urandom);
         rd_W       = AW'($urandom_range(7)); regwrite_W = 1'($urandom);
         redirect_E = ($urandom_range(7) == 0);
         md_start_E = ($urandom_range(3) == 0);
         md_done    = ($urandom_range(7) == 0);
         imem_ready = ($urandom_range(3) != 0);
         settle();
         n_tests++;
         if (ctrl !== exp_ctrl) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_ctrl cyc %0d: got %b want %b", c, ctrl, exp_ctrl);
         end
         n_tests++;
         if (perf_stalls !== exp_perf) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_perf cyc %0d: got %0d want %0d", c, perf_stalls, exp_perf);
         end
         n_tests++;
         if ((stall_D && flush_D) || (stall_E && flush_E)) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_invariant cyc %0d: got sD=%b fD=%b sE=%b fE=%b want no pair", c, stall_D, flush_D, stall_E, flush_E);
         end
         adv();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset_n = 0;
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_redirect_lu();
      test_md_done();
      test_redir_pend();
      test_fwd();
      test_md_timeout();
      test_reset_md();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
